// File: rtl/i2s_tx_if.sv
// rtl/i2s_tx_if.sv - sample strobe, control and I2S pin bundle for i2s_tx
interface i2s_tx_if;
  logic        iSampleValid;
  logic [15:0] iSample;
  logic        iMute;
  logic        iClrStatus;
  logic        oBclk;
  logic        oLrclk;
  logic        oSd;
  logic        oUnderrun;
  logic        oOverrun;

  modport master (
    output iSampleValid, iSample, iMute, iClrStatus,
    input  oBclk, oLrclk, oSd, oUnderrun, oOverrun
  );

  modport slave (
    input  iSampleValid, iSample, iMute, iClrStatus,
    output oBclk, oLrclk, oSd, oUnderrun, oOverrun
  );
endinterface

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter with one-frame pending buffer and sticky status
module i2s_tx #(
  parameter int CLK_DIV = 4,
  parameter bit MONO    = 1'b1
) (
  input  logic     iClk,
  input  logic     iRstN,
  i2s_tx_if.slave  bus
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_q, div_d;
  logic        bclk_q, bclk_d;
  logic        lrclk_q, lrclk_d;
  logic        sd_q, sd_d;
  logic [4:0]  n_q, n_d;
  logic [31:0] frame_q, frame_d;
  logic        shadow_q, shadow_d;
  logic [15:0] pend_l_q, pend_l_d;
  logic [15:0] pend_r_q, pend_r_d;
  logic        full_q, full_d;
  logic        ptr_q, ptr_d;
  logic        ur_q, ur_d;
  logic        ov_q, ov_d;

  logic        tc, fall, cap;
  logic [4:0]  bit_idx;

  assign tc      = (div_q == DIV_LAST);
  assign fall    = tc && bclk_q;
  assign n_d     = fall ? n_q + 5'd1 : n_q;
  assign cap     = fall && (n_q == 5'd0);
  // Slots 2..31 carry word bit 32-n, i.e. -n modulo 32.
  assign bit_idx = 5'd0 - n_d;

  always_comb begin
    logic set_ur;
    logic set_ov;
    div_d    = tc ? 8'd0 : div_q + 8'd1;
    bclk_d   = tc ? ~bclk_q : bclk_q;
    lrclk_d  = lrclk_q;
    sd_d     = sd_q;
    frame_d  = frame_q;
    shadow_d = shadow_q;
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    full_d   = full_q;
    ptr_d    = ptr_q;
    set_ur   = 1'b0;
    set_ov   = 1'b0;

    if (cap) begin
      if (full_q) frame_d = {pend_l_q, pend_r_q};
      else        set_ur  = 1'b1;
      if (bus.iMute) frame_d = 32'd0;
      shadow_d = frame_d[0];
      full_d   = 1'b0;
      ptr_d    = 1'b0;
    end

    // full_d already reflects a same-cycle capture, so that case never overruns.
    if (bus.iSampleValid) begin
      if (MONO) begin
        set_ov   = full_d;
        pend_l_d = bus.iSample;
        pend_r_d = bus.iSample;
        full_d   = 1'b1;
      end else if (!ptr_d) begin
        set_ov   = full_d;
        pend_l_d = bus.iSample;
        ptr_d    = 1'b1;
      end else begin
        pend_r_d = bus.iSample;
        ptr_d    = 1'b0;
        full_d   = 1'b1;
      end
    end

    if (fall) begin
      lrclk_d = n_d[4];
      case (n_d)
        5'd0:    sd_d = shadow_q;
        5'd1:    sd_d = frame_d[31];
        default: sd_d = frame_q[bit_idx];
      endcase
    end

    ur_d = (ur_q && !bus.iClrStatus) || set_ur;
    ov_d = (ov_q && !bus.iClrStatus) || set_ov;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      div_q    <= 8'd0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sd_q     <= 1'b0;
      n_q      <= 5'd0;
      frame_q  <= 32'd0;
      shadow_q <= 1'b0;
      pend_l_q <= 16'd0;
      pend_r_q <= 16'd0;
      full_q   <= 1'b0;
      ptr_q    <= 1'b0;
      ur_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sd_q     <= sd_d;
      n_q      <= n_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      full_q   <= full_d;
      ptr_q    <= ptr_d;
      ur_q     <= ur_d;
      ov_q     <= ov_d;
    end
  end

  assign bus.oBclk     = bclk_q;
  assign bus.oLrclk    = lrclk_q;
  assign bus.oSd       = sd_q;
  assign bus.oUnderrun = ur_q;
  assign bus.oOverrun  = ov_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed bench for i2s_tx, MONO=1 and MONO=0 instances side by side
module tb_i2s_tx;
  localparam int CD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_tx_if bus0 ();
  i2s_tx_if bus1 ();

  i2s_tx #(.CLK_DIV(CD), .MONO(1'b1)) dut0 (.iClk(clk), .iRstN(rst_n), .bus(bus0));
  i2s_tx #(.CLK_DIV(CD), .MONO(1'b0)) dut1 (.iClk(clk), .iRstN(rst_n), .bus(bus1));

  int n_pass  = 0;
  int n_total = 0;

  // Model: k = rising edges since reset release; per-instance buffer state.
  int          k;
  logic [15:0] m_l    [2];
  logic [15:0] m_r    [2];
  logic [31:0] m_word [2];
  bit          m_full [2];
  bit          m_ptr  [2];
  bit          m_ur   [2];
  bit          m_ov   [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
  endtask

  task automatic model_reset();
    k = 0;
    for (int d = 0; d < 2; d++) begin
      m_l[d] = '0; m_r[d] = '0; m_word[d] = '0;
      m_full[d] = 0; m_ptr[d] = 0; m_ur[d] = 0; m_ov[d] = 0;
    end
  endtask

  task automatic model_step();
    int  m, n;
    bit  cap;
    k++;
    m   = k / (2 * CD);
    n   = m % 32;
    cap = (k % (2 * CD) == 0) && (n == 1);
    for (int d = 0; d < 2; d++) begin
      bit set_ur, set_ov;
      set_ur = 0; set_ov = 0;
      if (cap) begin
        if (m_full[d]) m_word[d] = {m_l[d], m_r[d]};
        else           set_ur = 1;
        if (bus0.iMute) m_word[d] = 32'd0;
        m_full[d] = 0;
        m_ptr[d]  = 0;
      end
      if (bus0.iSampleValid) begin
        if (d == 0) begin
          if (m_full[d]) set_ov = 1;
          m_l[d] = bus0.iSample; m_r[d] = bus0.iSample; m_full[d] = 1;
        end else if (!m_ptr[d]) begin
          if (m_full[d]) set_ov = 1;
          m_l[d] = bus0.iSample; m_ptr[d] = 1;
        end else begin
          m_r[d] = bus0.iSample; m_ptr[d] = 0; m_full[d] = 1;
        end
      end
      m_ur[d] = (m_ur[d] && !bus0.iClrStatus) || set_ur;
      m_ov[d] = (m_ov[d] && !bus0.iClrStatus) || set_ov;
    end
  endtask

  task automatic compare_all();
    int m, n;
    logic e_bclk, e_lr, e_sd;
    m      = k / (2 * CD);
    n      = m % 32;
    e_bclk = 1'((k / CD) % 2);
    e_lr   = (n >= 16);
    e_sd   = m_word[0][31 - ((n + 31) % 32)];
    chk("bclk0", bus0.oBclk, e_bclk);
    chk("lrclk0", bus0.oLrclk, e_lr);
    chk("sd0", bus0.oSd, e_sd);
    chk("ur0", bus0.oUnderrun, m_ur[0]);
    chk("ov0", bus0.oOverrun, m_ov[0]);
    e_sd   = m_word[1][31 - ((n + 31) % 32)];
    chk("bclk1", bus1.oBclk, e_bclk);
    chk("lrclk1", bus1.oLrclk, e_lr);
    chk("sd1", bus1.oSd, e_sd);
    chk("ur1", bus1.oUnderrun, m_ur[1]);
    chk("ov1", bus1.oOverrun, m_ov[1]);
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) model_step();
    #1;
    compare_all();
  end

  task automatic set_in(input logic v, input logic [15:0] s, input logic mute, input logic clr);
    bus0.iSampleValid = v; bus0.iSample = s; bus0.iMute = mute; bus0.iClrStatus = clr;
    bus1.iSampleValid = v; bus1.iSample = s; bus1.iMute = mute; bus1.iClrStatus = clr;
  endtask

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (k < target) chk("wait_k_timeout", 32'(k), 32'(target));
  endtask

  // Drive so the strobe is sampled on rising edge K.
  task automatic strobe_at(input int kk, input logic [15:0] s, input logic mute);
    wait_k(kk - 1);
    set_in(1'b1, s, mute, 1'b0);
    @(negedge clk);
    set_in(1'b0, 16'd0, mute, 1'b0);
  endtask

  task automatic clr_at(input int kk);
    wait_k(kk - 1);
    set_in(1'b0, 16'd0, 1'b0, 1'b1);
    @(negedge clk);
    set_in(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    set_in(1'b0, 16'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_bclk", bus0.oBclk, 1'b0);
    chk("rst_lrclk", bus0.oLrclk, 1'b0);
    chk("rst_sd", bus0.oSd, 1'b0);
    chk("rst_ur", bus0.oUnderrun, 1'b0);
    chk("rst_ov", bus1.oOverrun, 1'b0);
    rst_n = 1'b1;

    strobe_at(2, 16'h8001, 1'b0);
    wait_k(5);   chk("s1_slot1_sd", bus0.oSd, 1'b1);
    wait_k(9);   chk("s1_slot2_sd", bus0.oSd, 1'b0);
    wait_k(64);  chk("s1_slot16_lr", bus0.oLrclk, 1'b1);
                 chk("s1_slot16_sd", bus0.oSd, 1'b1);
    wait_k(128); chk("s1_slot0_sd", bus0.oSd, 1'b1);
    wait_k(130); chk("s1_no_ur", bus0.oUnderrun, 1'b0);
    wait_k(133); chk("s2_ur", bus0.oUnderrun, 1'b1);
                 chk("s2_word", m_word[0], 32'h80018001);
    clr_at(140); chk("s2_clr", bus0.oUnderrun, 1'b0);

    strobe_at(150, 16'h1234, 1'b0);
    strobe_at(170, 16'h5678, 1'b0);
    chk("s3_ov", bus0.oOverrun, 1'b1);
    wait_k(261); chk("s3_word", m_word[0], 32'h56785678);

    clr_at(280);
    strobe_at(300, 16'h1111, 1'b0);
    strobe_at(388, 16'h2222, 1'b0);
    chk("s4_no_ov", bus0.oOverrun, 1'b0);
    chk("s4_word", m_word[0], 32'h11111111);
    wait_k(517); chk("s4_no_ur", bus0.oUnderrun, 1'b0);
                 chk("s4_next_word", m_word[0], 32'h22222222);

    strobe_at(560, 16'hAAAA, 1'b0);
    strobe_at(580, 16'h5555, 1'b0);
    wait_k(645); chk("s5_word", m_word[1], 32'hAAAA5555);
    wait_k(769); chk("s5_slot0_sd", bus1.oSd, 1'b1);

    strobe_at(800, 16'h7FFF, 1'b0);
    wait_k(850); set_in(1'b0, 16'd0, 1'b1, 1'b0);
    wait_k(901); chk("s6_mute_word", m_word[0], 32'd0);
    wait_k(950); set_in(1'b0, 16'd0, 1'b0, 1'b0);

    wait_k(960);
    chk("s6_pre_lr", bus0.oLrclk, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_lr", bus0.oLrclk, 1'b0);
    chk("s6_rst_ur0", bus0.oUnderrun, 1'b0);
    chk("s6_rst_ur1", bus1.oUnderrun, 1'b0);
    chk("s6_rst_sd", bus1.oSd, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: oBclk half-period in iClk cycles; legal range 1..255.
REQ-002 Parameter MONO, default 1: 1 = left and right slots both carry the same sample; 0 = alternate samples go to left then right.
REQ-003 iClk  input  1  single system clock; all logic on rising edge.
REQ-004 iRstN  input  1  asynchronous, active-low reset.
REQ-005 iSampleValid  input  1  one-cycle strobe; iSample is valid this cycle (driven by the synthesizer's sample clock-enable).
REQ-006 iSample  input  16  signed two's-complement PCM sample.
REQ-007 iMute  input  1  when high, captured frames are zeroed.
REQ-008 iClrStatus  input  1  one-cycle strobe; clears oUnderrun and oOverrun.
REQ-009 oBclk  output  1  I2S bit clock.
REQ-010 oLrclk  output  1  I2S word select; 0 = left slot, 1 = right slot.
REQ-011 oSd  output  1  I2S serial data, MSB first.
REQ-012 oUnderrun  output  1  sticky: a frame started with no new sample pending.
REQ-013 oOverrun  output  1  sticky: a sample arrived while the pending buffer was still full.

Function
REQ-014 Divider counter runs 0..CLK_DIV-1; on terminal count it wraps and oBclk toggles. A 1->0 toggle is a "falling event".
REQ-015 5-bit slot counter n increments (mod 32) on each falling event; frame = 32 BCLK periods, 16 per channel.
REQ-016 On each falling event, oLrclk <= (new n >= 16).
REQ-017 oSd updates only on falling events, with one-BCLK I2S delay: slot n carries frame-word bit 31-((n+31) mod 32); slot 0 carries the right-channel LSB of the previous frame (held in a 1-bit shadow).
REQ-018 Frame word = {left[15:0], right[15:0]}; captured from the pending buffer on the falling event that enters slot 1, before the slot-1 bit is driven.
REQ-019 Pending buffer: MONO=1 -> one 16-bit register plus full flag; MONO=0 -> left/right registers plus full flag set after the right sample is written.
REQ-020 On iSampleValid: write pending, set full. If full was already set and not consumed in the same cycle, the new sample overwrites and oOverrun sets.
REQ-021 On frame capture with full=1: load pending, clear full. With full=0: reload the previous frame word unchanged and set oUnderrun.
REQ-022 Simultaneous iSampleValid and capture in one cycle: capture takes the old pending contents, the new sample is written, full stays 1, no overrun.
REQ-023 iMute high at capture: frame word loaded as 0; full handling is unchanged.
REQ-024 iClrStatus clears both sticky flags; a set condition in the same cycle wins.
REQ-025 Latency: a sample strobed before the capture event appears on oSd starting at slot 1 of that frame; worst case is one frame plus one slot.
REQ-026 MONO=0 pairing: first strobe after reset or capture goes to left, second to right; a third strobe before capture restarts at left and sets oOverrun.

Reset
REQ-027 While iRstN is low: oBclk=0, oLrclk=0, oSd=0, oUnderrun=0, oOverrun=0, divider=0, n=0, frame word=0, shadow=0, pending=0, full=0, MONO=0 channel pointer=left.
REQ-028 Release of iRstN starts the divider on the next rising iClk edge; the first falling event occurs after 2*CLK_DIV cycles.
REQ-029 Asserting reset mid-frame aborts immediately, with no partial-frame completion.

Verification
REQ-030 CLK_DIV=2, MONO=1, iSample=16'h8001 strobed once before first capture -> slots 1..16 and 17..32 show 1000_0000_0000_0001 on oSd; oLrclk high for slots 16..31; oUnderrun=0.
REQ-031 No further strobes after scenario 1 -> next frame repeats 16'h8001 and oUnderrun=1; iClrStatus -> oUnderrun=0 next cycle.
REQ-032 Two strobes (16'h1234 then 16'h5678) within one frame -> next frame carries 16'h5678 and oOverrun=1.
REQ-033 Strobe in the exact cycle of capture -> captured frame holds the old pending value, full=1 afterwards, oOverrun=0.
REQ-034 MONO=0, strobes 16'hAAAA then 16'h5555 -> left slot 16'hAAAA, right slot 16'h5555; next frame slot 0 oSd=1 (right LSB).
REQ-035 iMute=1 with 16'h7FFF pending -> oSd=0 for the whole frame and full clears; reset asserted mid-frame -> all outputs 0 within the same cycle.
